// File: rtl/enc_key_sched.sv
// enc_key_sched: streams ROUNDS 9-bit round keys from a 144-bit master key over valid/ready.
// Optional macro KEY_ZEROIZE_EN wipes the key register and rk_data once the stream completes.
module enc_key_sched #(
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [143:0] key_in,
  input  logic         load,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [8:0]   rk_data,
  output logic [6:0]   rk_round,
  output logic         rk_last,
  output logic         done
);
  localparam logic [6:0] LP_LAST = 7'(ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [143:0]   r_key;
  logic [6:0]     r_round;
  logic [8:0]     r_data;
  logic           r_busy;
  logic           r_valid;
  logic           r_last;
  logic           r_done;
  logic [6:0]     w_next_round;
  logic           w_xfer;

  assign w_next_round = r_round + 7'd1;
  assign w_xfer       = r_valid & rk_ready;

  // Word index wraps every 16 rounds; the full 7-bit round number is XORed in.
  function automatic logic [8:0] f_round_key(input logic [143:0] key, input logic [6:0] rnd);
    logic [6:0] idx;
    logic [7:0] base;
    idx  = rnd - 7'd1;
    base = {4'b0000, idx[3:0]} * 8'd9;
    return key[base +: 9] ^ {2'b00, rnd};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_xfer) begin
            if (r_round == LP_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
`ifdef KEY_ZEROIZE_EN
              r_key   <= '0;
              r_data  <= '0;
`endif
            end else begin
              r_round <= w_next_round;
              r_data  <= f_round_key(r_key, w_next_round);
              r_last  <= (w_next_round == LP_LAST);
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new load; DONE lasts only for the done pulse.
          r_done <= 1'b0;
          if (load) begin
            r_state <= S_RUN;
            r_key   <= key_in;
            r_round <= 7'd1;
            r_data  <= f_round_key(key_in, 7'd1);
            r_last  <= (LP_LAST == 7'd1);
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign rk_data  = r_data;
  assign rk_round = r_round;
  assign rk_last  = r_last;
  assign done     = r_done;

endmodule

// File: tb/tb_enc_key_sched.sv
// Bench for enc_key_sched: a 16-round and a 20-round instance driven by table, hand and random sequences.
// Expected keys come from a direct model of the round-key rule.
module tb_enc_key_sched;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [143:0] key_in;
  logic         load  [2];
  logic         ready [2];
  logic         busy  [2];
  logic         valid [2];
  logic         last  [2];
  logic         done  [2];
  logic [8:0]   data  [2];
  logic [6:0]   rnd   [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enc_key_sched #(.ROUNDS(16)) u0 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .load(load[0]), .busy(busy[0]),
    .rk_valid(valid[0]), .rk_ready(ready[0]), .rk_data(data[0]), .rk_round(rnd[0]),
    .rk_last(last[0]), .done(done[0])
  );

  enc_key_sched #(.ROUNDS(20)) u1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .load(load[1]), .busy(busy[1]),
    .rk_valid(valid[1]), .rk_ready(ready[1]), .rk_data(data[1]), .rk_round(rnd[1]),
    .rk_last(last[1]), .done(done[1])
  );

  typedef struct {
    int         idx;
    int         round;
    logic [8:0] exp_data;
    logic       exp_last;
  } vec_t;

  function automatic int nrounds(input int idx);
    return (idx == 0) ? 16 : 20;
  endfunction

  function automatic logic [8:0] ref_key(input logic [143:0] key, input int r);
    int w;
    logic [8:0] word;
    w    = (r - 1) % 16;
    word = key[9*w +: 9];
    return word ^ 9'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int idx);
    int b;
    b = 0;
    ready[idx] = 1'b1;
    while (!done[idx] && b < 100) begin
      step();
      b++;
    end
    if (!done[idx]) timeout("drain");
    step();
    chk("idle_busy", busy[idx], 0);
    chk("idle_done", done[idx], 0);
  endtask

  // Loads key, then checks every cycle against the model until the last key transfers.
  task automatic run_stream(input int idx, input logic [143:0] key, input int pct_ready,
                            input int load_at, input bit load_on_done);
    int r, budget, nr;
    bit took;
    logic [143:0] key2;
    logic [8:0] exp_z;
    r = 1; budget = 0; nr = nrounds(idx);
    key_in = key; load[idx] = 1'b1;
    step();
    load[idx] = 1'b0;
    key_in = ~key;
    while (r <= nr && budget < 1000) begin
      chk("valid", valid[idx], 1);
      chk("busy", busy[idx], 1);
      chk("round", rnd[idx], r);
      chk("data", data[idx], ref_key(key, r));
      chk("last", last[idx], (r == nr));
      chk("done_low", done[idx], 0);
      took = (int'($urandom_range(99)) < pct_ready);
      ready[idx] = took;
      load[idx] = (r == load_at);
      step();
      budget++;
      load[idx] = 1'b0;
      if (took) r++;
    end
    if (r <= nr) timeout("stream");
`ifdef KEY_ZEROIZE_EN
    exp_z = 9'h000;
`else
    exp_z = ref_key(key, nr);
`endif
    chk("end_valid", valid[idx], 0);
    chk("end_busy", busy[idx], 0);
    chk("end_done", done[idx], 1);
    chk("end_data", data[idx], exp_z);
    if (load_on_done) begin
      key2 = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
      key_in = key2; load[idx] = 1'b1;
      step();
      load[idx] = 1'b0;
      chk("reload_valid", valid[idx], 1);
      chk("reload_round", rnd[idx], 1);
      chk("reload_data", data[idx], ref_key(key2, 1));
      drain(idx);
    end else begin
      step();
      chk("post_done", done[idx], 0);
      chk("post_valid", valid[idx], 0);
    end
  endtask

  initial begin
    logic [143:0] k100;
    logic [143:0] kr;
    vec_t tbl[7];
    int b, idx;

    for (int n = 0; n < 16; n++) k100[9*n +: 9] = 9'h100 + 9'(n);
    tbl[0] = '{0, 1,  9'h101, 1'b0};
    tbl[1] = '{0, 2,  9'h103, 1'b0};
    tbl[2] = '{0, 3,  9'h101, 1'b0};
    tbl[3] = '{0, 16, 9'h11F, 1'b1};
    tbl[4] = '{1, 16, 9'h11F, 1'b0};
    tbl[5] = '{1, 17, 9'h111, 1'b0};
    tbl[6] = '{1, 20, 9'h117, 1'b1};

    rst_n = 1'b0; key_in = '0;
    for (int i = 0; i < 2; i++) begin load[i] = 1'b0; ready[i] = 1'b0; end
    step(); step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_valid", valid[i], 0);
      chk("rst_data", data[i], 0);
      chk("rst_round", rnd[i], 0);
      chk("rst_last", last[i], 0);
      chk("rst_done", done[i], 0);
    end
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 7; t++) begin
      idx = tbl[t].idx;
      key_in = k100; load[idx] = 1'b1; ready[idx] = 1'b1;
      step();
      load[idx] = 1'b0;
      b = 0;
      while (!(valid[idx] && int'(rnd[idx]) == tbl[t].round) && b < 50) begin
        step();
        b++;
      end
      chk("tbl_round", rnd[idx], tbl[t].round);
      chk("tbl_data", data[idx], tbl[t].exp_data);
      chk("tbl_last", last[idx], tbl[t].exp_last);
      drain(0 + idx);
    end

    // Backpressure at round 3 for five cycles.
    key_in = k100; load[0] = 1'b1; ready[0] = 1'b1;
    step();
    load[0] = 1'b0;
    b = 0;
    while (rnd[0] != 7'd3 && b < 20) begin step(); b++; end
    ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_round", rnd[0], 3);
      chk("bp_data", data[0], 9'h101);
      chk("bp_valid", valid[0], 1);
      step();
    end
    ready[0] = 1'b1;
    step();
    chk("bp_next_round", rnd[0], 4);
    chk("bp_next_data", data[0], 9'h107);
    drain(0);

    // Load during RUN at round 5 must be ignored.
    run_stream(0, k100, 100, 5, 1'b0);

    // Reset mid-stream at round 7, then restart.
    key_in = k100; load[0] = 1'b1; ready[0] = 1'b1;
    step();
    load[0] = 1'b0;
    b = 0;
    while (rnd[0] != 7'd7 && b < 20) begin step(); b++; end
    chk("pre_rst_round", rnd[0], 7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", valid[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_data", data[0], 0);
    chk("mid_rst_round", rnd[0], 0);
    chk("mid_rst_last", last[0], 0);
    chk("mid_rst_done", done[0], 0);
    run_stream(0, k100, 100, 0, 1'b0);

    // Back-to-back reload on the done cycle, on both widths.
    run_stream(0, k100, 100, 0, 1'b1);
    run_stream(1, k100, 100, 0, 1'b1);

    for (int it = 0; it < 10; it++) begin
      kr  = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
      idx = int'($urandom_range(1));
      run_stream(idx, kr, int'($urandom_range(100, 25)), int'($urandom_range(25)),
                 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
